// File: rtl/monitor_rr_if.sv
// Transaction bundle between a stimulus source (master) and the monitor_rr scoreboard (slave).
interface monitor_rr_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic [WIDTH-1:0] i_dut_ia;
    logic [WIDTH-1:0] i_dut_ib;
    logic [WIDTH-1:0] i_dut_os;
    logic             i_clear;
    logic             o_ready;
    logic             o_drop;
    logic             o_event;
    logic [CNT_W-1:0] o_err_cnt;
    logic [CNT_W-1:0] o_txn_cnt;
    logic             o_first_vld;
    logic [WIDTH-1:0] o_first_a;
    logic [WIDTH-1:0] o_first_b;
    logic [WIDTH-1:0] o_first_os;

    modport master (
        output i_valid, i_dut_ia, i_dut_ib, i_dut_os, i_clear,
        input  o_ready, o_drop, o_event, o_err_cnt, o_txn_cnt,
               o_first_vld, o_first_a, o_first_b, o_first_os
    );

    modport slave (
        input  i_valid, i_dut_ia, i_dut_ib, i_dut_os, i_clear,
        output o_ready, o_drop, o_event, o_err_cnt, o_txn_cnt,
               o_first_vld, o_first_a, o_first_b, o_first_os
    );
endinterface

// File: rtl/monitor_rr.sv
// Round-robin reference scoreboard: lanes recompute a DUT op over LANE_LAT cycles and flag mismatches.
// Define MONITOR_FIRST_CAPTURE_EN to keep a snapshot of the first failing transaction.
module monitor_rr #(
    parameter int WIDTH       = 32,
    parameter int NUM_SUB_MON = 4,
    parameter int LANE_LAT    = 4,
    parameter int OP          = 0,
    parameter int CNT_W       = 16
) (
    input logic         clk,
    input logic         reset,
    monitor_rr_if.slave bus
);
    localparam int PTR_W = (NUM_SUB_MON > 1) ? $clog2(NUM_SUB_MON) : 1;
    localparam int LAT_W = (LANE_LAT > 1) ? $clog2(LANE_LAT) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SUB_MON - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LANE_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [PTR_W-1:0]       ptr;
    logic [NUM_SUB_MON-1:0] busy;
    logic [NUM_SUB_MON-1:0] done;
    logic [LAT_W-1:0]       cnt     [NUM_SUB_MON];
    logic [WIDTH-1:0]       lane_a  [NUM_SUB_MON];
    logic [WIDTH-1:0]       lane_b  [NUM_SUB_MON];
    logic [WIDTH-1:0]       lane_os [NUM_SUB_MON];

    logic             ready;
    logic             accept;
    logic             cmp_hit;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic [WIDTH-1:0] cmp_os;
    logic             mismatch;

    logic             drop_q;
    logic             event_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] txn_q;

    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        case (OP)
            1:       return a - b;
            2:       return a * b;
            3:       return a ^ b;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SUB_MON; i++) begin
            done[i] = busy[i] && (cnt[i] == '0);
        end
    end

    assign ready       = !busy[ptr] || done[ptr];
    assign accept      = bus.i_valid && ready;
    assign bus.o_ready = ready;

    // Accepts are serial and latency is fixed, so at most one lane is done per cycle.
    // NOTE: every signal gets a default before the loop so no path can infer a latch.
    always_comb begin
        cmp_hit = 1'b0;
        cmp_a   = '0;
        cmp_b   = '0;
        cmp_os  = '0;
        for (int i = 0; i < NUM_SUB_MON; i++) begin
            if (done[i]) begin
                cmp_hit = 1'b1;
                cmp_a   = lane_a[i];
                cmp_b   = lane_b[i];
                cmp_os  = lane_os[i];
            end
        end
    end

    assign mismatch = cmp_hit && (ref_result(cmp_a, cmp_b) != cmp_os);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr  <= '0;
            busy <= '0;
            for (int i = 0; i < NUM_SUB_MON; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
            for (int i = 0; i < NUM_SUB_MON; i++) begin
                if (accept && (ptr == PTR_W'(i))) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= LAT_LOAD;
                end else if (done[i]) begin
                    busy[i] <= 1'b0;
                end else if (busy[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: lane payload has no reset; busy gates every read, so stale contents are never compared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SUB_MON; i++) begin
            if (accept && (ptr == PTR_W'(i))) begin
                lane_a[i]  <= bus.i_dut_ia;
                lane_b[i]  <= bus.i_dut_ib;
                lane_os[i] <= bus.i_dut_os;
            end
        end
    end

    // A clear on a compare edge zeroes the count and then counts that compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q  <= 1'b0;
            event_q <= 1'b0;
            err_q   <= '0;
            txn_q   <= '0;
        end else begin
            drop_q  <= bus.i_valid && !ready;
            event_q <= mismatch;
            if (bus.i_clear) begin
                txn_q <= CNT_W'(cmp_hit);
                err_q <= CNT_W'(mismatch);
            end else begin
                if (cmp_hit && (txn_q != CNT_MAX)) txn_q <= txn_q + 1'b1;
                if (mismatch && (err_q != CNT_MAX)) err_q <= err_q + 1'b1;
            end
        end
    end

    assign bus.o_drop    = drop_q;
    assign bus.o_event   = event_q;
    assign bus.o_err_cnt = err_q;
    assign bus.o_txn_cnt = txn_q;

`ifdef MONITOR_FIRST_CAPTURE_EN
    logic             first_vld_q;
    logic [WIDTH-1:0] first_a_q;
    logic [WIDTH-1:0] first_b_q;
    logic [WIDTH-1:0] first_os_q;

    // Clear re-arms the capture, so a mismatch on the clear edge becomes the new snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_vld_q <= 1'b0;
            first_a_q   <= '0;
            first_b_q   <= '0;
            first_os_q  <= '0;
        end else if (mismatch && (bus.i_clear || !first_vld_q)) begin
            first_vld_q <= 1'b1;
            first_a_q   <= cmp_a;
            first_b_q   <= cmp_b;
            first_os_q  <= cmp_os;
        end else if (bus.i_clear) begin
            first_vld_q <= 1'b0;
        end
    end

    assign bus.o_first_vld = first_vld_q;
    assign bus.o_first_a   = first_a_q;
    assign bus.o_first_b   = first_b_q;
    assign bus.o_first_os  = first_os_q;
`else
    assign bus.o_first_vld = 1'b0;
    assign bus.o_first_a   = '0;
    assign bus.o_first_b   = '0;
    assign bus.o_first_os  = '0;
`endif
endmodule

// File: tb/tb_monitor_rr.sv
// Self-checking bench for monitor_rr: five parameter sets, expected compares queued at accept time.
`timescale 1ns/1ps
module tb_monitor_rr;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_eval = 0;
    int   n_fail = 0;

    typedef struct {
        int   due;
        logic ev;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    monitor_rr_if #(.WIDTH(32), .CNT_W(16)) b0 ();
    monitor_rr_if #(.WIDTH(32), .CNT_W(16)) b1 ();
    monitor_rr_if #(.WIDTH(8),  .CNT_W(16)) b2 ();
    monitor_rr_if #(.WIDTH(32), .CNT_W(2))  b3 ();
    monitor_rr_if #(.WIDTH(16), .CNT_W(8))  b4 ();

    monitor_rr #(.WIDTH(32), .NUM_SUB_MON(4), .LANE_LAT(4), .OP(0), .CNT_W(16))
        u0 (.clk(clk), .reset(reset), .bus(b0));
    monitor_rr #(.WIDTH(32), .NUM_SUB_MON(2), .LANE_LAT(4), .OP(0), .CNT_W(16))
        u1 (.clk(clk), .reset(reset), .bus(b1));
    monitor_rr #(.WIDTH(8),  .NUM_SUB_MON(4), .LANE_LAT(4), .OP(2), .CNT_W(16))
        u2 (.clk(clk), .reset(reset), .bus(b2));
    monitor_rr #(.WIDTH(32), .NUM_SUB_MON(4), .LANE_LAT(4), .OP(1), .CNT_W(2))
        u3 (.clk(clk), .reset(reset), .bus(b3));
    monitor_rr #(.WIDTH(16), .NUM_SUB_MON(1), .LANE_LAT(1), .OP(3), .CNT_W(8))
        u4 (.clk(clk), .reset(reset), .bus(b4));

    function automatic void sb_push(input int due, input logic ev);
        sb_t s;
        s.due = due;
        s.ev  = ev;
        sbq.push_back(s);
    endfunction

    function automatic void sb_pop(input int e, output logic hit, output logic ev);
        hit = 1'b0;
        ev  = 1'b0;
        if (sbq.size() != 0 && sbq[0].due == e) begin
            hit = 1'b1;
            ev  = sbq[0].ev;
            void'(sbq.pop_front());
        end
    endfunction

    function automatic int sat_next(input int cur, input logic inc, input logic clr, input int max);
        if (clr) return inc ? 1 : 0;
        if (inc && cur < max) return cur + 1;
        return cur;
    endfunction

    task automatic idle_all();
        b0.i_valid = 1'b0; b0.i_clear = 1'b0; b0.i_dut_ia = '0; b0.i_dut_ib = '0; b0.i_dut_os = '0;
        b1.i_valid = 1'b0; b1.i_clear = 1'b0; b1.i_dut_ia = '0; b1.i_dut_ib = '0; b1.i_dut_os = '0;
        b2.i_valid = 1'b0; b2.i_clear = 1'b0; b2.i_dut_ia = '0; b2.i_dut_ib = '0; b2.i_dut_os = '0;
        b3.i_valid = 1'b0; b3.i_clear = 1'b0; b3.i_dut_ia = '0; b3.i_dut_ib = '0; b3.i_dut_os = '0;
        b4.i_valid = 1'b0; b4.i_clear = 1'b0; b4.i_dut_ia = '0; b4.i_dut_ib = '0; b4.i_dut_os = '0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_eval++;
        if ({b0.o_ready, b0.o_drop, b0.o_event, b0.o_first_vld} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags_u0: got %b want 1000",
                     {b0.o_ready, b0.o_drop, b0.o_event, b0.o_first_vld});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_eval++;
        if ({b0.o_err_cnt, b0.o_txn_cnt} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts_u0: got err=%0d txn=%0d want 0 0", b0.o_err_cnt, b0.o_txn_cnt);
        end
        n_eval++;
        if ({b0.o_first_a, b0.o_first_b, b0.o_first_os} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_snapshot_u0: got %h %h %h want 0", b0.o_first_a, b0.o_first_b, b0.o_first_os);
        end
        n_eval++;
        if ({b1.o_ready, b2.o_ready, b3.o_ready, b4.o_ready} !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_ready_others: got %b want 1111",
                     {b1.o_ready, b2.o_ready, b3.o_ready, b4.o_ready});
        end
        n_eval++;
        if ({b1.o_event, b2.o_event, b3.o_event, b4.o_event, b3.o_err_cnt, b4.o_txn_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state_others: got events %b err3=%0d txn4=%0d want 0",
                     {b1.o_event, b2.o_event, b3.o_event, b4.o_event}, b3.o_err_cnt, b4.o_txn_cnt);
        end
    endtask

    task automatic test_full_rate();
        logic hit, ev;
        logic [31:0] a, b;
        int exp_txn = 0;
        sbq.delete();
        for (int c = 0; c < 106; c++) begin
            b0.i_valid = (c < 100);
            if (c < 100) begin
                a = $urandom;
                b = $urandom;
                b0.i_dut_ia = a;
                b0.i_dut_ib = b;
                b0.i_dut_os = a + b;
                n_eval++;
                if (b0.o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_ready c=%0d: got %b want 1", c, b0.o_ready);
                end
                sb_push(c + 4, 1'b0);
            end
            @(posedge clk); #1;
            sb_pop(c, hit, ev);
            exp_txn = sat_next(exp_txn, hit, 1'b0, 65535);
            n_eval++;
            if (b0.o_event !== ev || b0.o_drop !== 1'b0) begin
                n_fail++;
                $display("FAIL full_event c=%0d: got event=%b drop=%b want %b 0", c, b0.o_event, b0.o_drop, ev);
            end
            n_eval++;
            if (b0.o_txn_cnt !== 16'(exp_txn) || b0.o_err_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL full_counts c=%0d: got txn=%0d err=%0d want %0d 0",
                         c, b0.o_txn_cnt, b0.o_err_cnt, exp_txn);
            end
        end
        n_eval++;
        if (b0.o_txn_cnt !== 16'd100 || b0.o_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL full_total: got txn=%0d err=%0d want 100 0", b0.o_txn_cnt, b0.o_err_cnt);
        end
    endtask

    task automatic test_mismatch();
        logic hit, ev;
        logic [31:0] a, b, os;
        int exp_txn = 0, exp_err = 0;
        logic [95:0] exp_snap;
        logic        exp_vld;
        sbq.delete();
        b0.i_clear = 1'b1;
        @(posedge clk); #1;
        b0.i_clear = 1'b0;
        n_eval++;
        if (b0.o_txn_cnt !== 16'd0 || b0.o_err_cnt !== 16'd0 || b0.o_first_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_counts: got txn=%0d err=%0d vld=%b want 0 0 0",
                     b0.o_txn_cnt, b0.o_err_cnt, b0.o_first_vld);
        end
        for (int c = 0; c < 18; c++) begin
            b0.i_valid = (c < 12);
            if (c < 12) begin
                a  = $urandom;
                b  = $urandom;
                os = a + b;
                if (c == 7) begin a = 32'd5; b = 32'd3; os = 32'd9; end
                if (c == 9) begin a = 32'd7; b = 32'd1; os = 32'd0; end
                b0.i_dut_ia = a;
                b0.i_dut_ib = b;
                b0.i_dut_os = os;
                sb_push(c + 4, (a + b) != os);
            end
            @(posedge clk); #1;
            sb_pop(c, hit, ev);
            exp_txn = sat_next(exp_txn, hit, 1'b0, 65535);
            exp_err = sat_next(exp_err, hit && ev, 1'b0, 65535);
            n_eval++;
            if (b0.o_event !== ev) begin
                n_fail++;
                $display("FAIL mismatch_event c=%0d: got %b want %b", c, b0.o_event, ev);
            end
            n_eval++;
            if (b0.o_err_cnt !== 16'(exp_err) || b0.o_txn_cnt !== 16'(exp_txn)) begin
                n_fail++;
                $display("FAIL mismatch_counts c=%0d: got err=%0d txn=%0d want %0d %0d",
                         c, b0.o_err_cnt, b0.o_txn_cnt, exp_err, exp_txn);
            end
        end
`ifdef MONITOR_FIRST_CAPTURE_EN
        exp_vld  = 1'b1;
        exp_snap = {32'd5, 32'd3, 32'd9};
`else
        exp_vld  = 1'b0;
        exp_snap = '0;
`endif
        n_eval++;
        if (b0.o_first_vld !== exp_vld || {b0.o_first_a, b0.o_first_b, b0.o_first_os} !== exp_snap) begin
            n_fail++;
            $display("FAIL mismatch_snapshot: got vld=%b %0d %0d %0d want vld=%b %h",
                     b0.o_first_vld, b0.o_first_a, b0.o_first_b, b0.o_first_os, exp_vld, exp_snap);
        end
    endtask

    task automatic test_drop();
        logic [0:13] pat;
        logic hit, ev, rdy, v, mis;
        logic [31:0] a, b;
        int lane_next [2];
        int p = 0, exp_txn = 0, exp_err = 0;
        pat = 14'b11111101111100;
        lane_next[0] = 0;
        lane_next[1] = 0;
        sbq.delete();
        for (int c = 0; c < 20; c++) begin
            v   = (c < 14) ? pat[c] : 1'b0;
            rdy = (c >= lane_next[p]);
            mis = (c == 4);
            a   = $urandom;
            b   = $urandom;
            b1.i_valid  = v;
            b1.i_dut_ia = a;
            b1.i_dut_ib = b;
            b1.i_dut_os = a + b + 32'(mis);
            n_eval++;
            if (b1.o_ready !== rdy) begin
                n_fail++;
                $display("FAIL drop_ready c=%0d: got %b want %b", c, b1.o_ready, rdy);
            end
            if (v && rdy) begin
                sb_push(c + 4, mis);
                lane_next[p] = c + 4;
                p = (p + 1) % 2;
            end
            @(posedge clk); #1;
            sb_pop(c, hit, ev);
            exp_txn = sat_next(exp_txn, hit, 1'b0, 65535);
            exp_err = sat_next(exp_err, hit && ev, 1'b0, 65535);
            n_eval++;
            if (b1.o_drop !== (v && !rdy) || b1.o_event !== ev) begin
                n_fail++;
                $display("FAIL drop_pulse c=%0d: got drop=%b event=%b want %b %b",
                         c, b1.o_drop, b1.o_event, v && !rdy, ev);
            end
            n_eval++;
            if (b1.o_txn_cnt !== 16'(exp_txn) || b1.o_err_cnt !== 16'(exp_err)) begin
                n_fail++;
                $display("FAIL drop_counts c=%0d: got txn=%0d err=%0d want %0d %0d",
                         c, b1.o_txn_cnt, b1.o_err_cnt, exp_txn, exp_err);
            end
        end
    endtask

    task automatic test_mul_trunc();
        logic [7:0]  ta  [5];
        logic [7:0]  tb  [5];
        logic [7:0]  tos [5];
        logic [15:0] full;
        logic hit, ev;
        ta  = '{8'h10, 8'h03, 8'hFF, 8'h12, 8'h0B};
        tb  = '{8'h10, 8'h05, 8'hFF, 8'h10, 8'h0D};
        tos = '{8'h00, 8'h0F, 8'h01, 8'h21, 8'h8F};
        sbq.delete();
        for (int c = 0; c < 10; c++) begin
            b2.i_valid = (c < 5);
            if (c < 5) begin
                b2.i_dut_ia = ta[c];
                b2.i_dut_ib = tb[c];
                b2.i_dut_os = tos[c];
                full = 16'(ta[c]) * 16'(tb[c]);
                sb_push(c + 4, full[7:0] != tos[c]);
            end
            @(posedge clk); #1;
            sb_pop(c, hit, ev);
            n_eval++;
            if (b2.o_event !== ev) begin
                n_fail++;
                $display("FAIL mul_event c=%0d: got %b want %b", c, b2.o_event, ev);
            end
        end
        n_eval++;
        if (b2.o_txn_cnt !== 16'd5 || b2.o_err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mul_counts: got txn=%0d err=%0d want 5 1", b2.o_txn_cnt, b2.o_err_cnt);
        end
    endtask

    task automatic test_saturate_clear();
        logic hit, ev, clr;
        logic [31:0] a, b;
        int exp_txn = 0, exp_err = 0;
        sbq.delete();
        for (int c = 0; c < 12; c++) begin
            clr = (c == 8);
            b3.i_valid = (c < 5);
            b3.i_clear = clr;
            if (c < 5) begin
                a = $urandom;
                b = $urandom;
                b3.i_dut_ia = a;
                b3.i_dut_ib = b;
                b3.i_dut_os = a - b + 32'd1;
                sb_push(c + 4, 1'b1);
            end
            @(posedge clk); #1;
            b3.i_clear = 1'b0;
            sb_pop(c, hit, ev);
            exp_txn = sat_next(exp_txn, hit, clr, 3);
            exp_err = sat_next(exp_err, hit && ev, clr, 3);
            n_eval++;
            if (b3.o_event !== ev) begin
                n_fail++;
                $display("FAIL sat_event c=%0d: got %b want %b", c, b3.o_event, ev);
            end
            n_eval++;
            if (b3.o_err_cnt !== 2'(exp_err) || b3.o_txn_cnt !== 2'(exp_txn)) begin
                n_fail++;
                $display("FAIL sat_counts c=%0d: got err=%0d txn=%0d want %0d %0d",
                         c, b3.o_err_cnt, b3.o_txn_cnt, exp_err, exp_txn);
            end
        end
        n_eval++;
        if (b3.o_err_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_after_clear: got err=%0d want 1", b3.o_err_cnt);
        end
    endtask

    task automatic test_back_to_back_xor();
        logic hit, ev, mis;
        logic [15:0] a, b;
        logic [47:0] first_snap;
        logic [47:0] exp_snap;
        logic        exp_vld;
        int exp_err = 0;
        first_snap = '0;
        sbq.delete();
        for (int c = 0; c < 12; c++) begin
            b4.i_valid = (c < 10);
            if (c < 10) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                mis = (c == 3) || (c == 6);
                b4.i_dut_ia = a;
                b4.i_dut_ib = b;
                b4.i_dut_os = (a ^ b) ^ (mis ? 16'h0100 : 16'h0000);
                if (c == 3) first_snap = {a, b, (a ^ b) ^ 16'h0100};
                n_eval++;
                if (b4.o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL xor_ready c=%0d: got %b want 1", c, b4.o_ready);
                end
                sb_push(c + 1, mis);
            end
            @(posedge clk); #1;
            sb_pop(c, hit, ev);
            exp_err = sat_next(exp_err, hit && ev, 1'b0, 255);
            n_eval++;
            if (b4.o_event !== ev || b4.o_err_cnt !== 8'(exp_err)) begin
                n_fail++;
                $display("FAIL xor_event c=%0d: got event=%b err=%0d want %b %0d",
                         c, b4.o_event, b4.o_err_cnt, ev, exp_err);
            end
        end
`ifdef MONITOR_FIRST_CAPTURE_EN
        exp_vld  = 1'b1;
        exp_snap = first_snap;
`else
        exp_vld  = 1'b0;
        exp_snap = '0;
`endif
        n_eval++;
        if (b4.o_txn_cnt !== 8'd10 || b4.o_first_vld !== exp_vld ||
            {b4.o_first_a, b4.o_first_b, b4.o_first_os} !== exp_snap) begin
            n_fail++;
            $display("FAIL xor_final: got txn=%0d vld=%b snap=%h want 10 %b %h", b4.o_txn_cnt,
                     b4.o_first_vld, {b4.o_first_a, b4.o_first_b, b4.o_first_os}, exp_vld, exp_snap);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        b0.i_clear = 1'b1;
        @(posedge clk); #1;
        b0.i_clear = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = $urandom;
            b = $urandom;
            b0.i_valid  = 1'b1;
            b0.i_dut_ia = a;
            b0.i_dut_ib = b;
            b0.i_dut_os = (c == 1) ? a + b + 32'd4 : a + b;
            @(posedge clk); #1;
        end
        b0.i_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_eval++;
            if (b0.o_event !== 1'b0 || b0.o_drop !== 1'b0 || b0.o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_flags c=%0d: got event=%b drop=%b ready=%b want 0 0 1",
                         c, b0.o_event, b0.o_drop, b0.o_ready);
            end
            n_eval++;
            if (b0.o_err_cnt !== 16'd0 || b0.o_txn_cnt !== 16'd0 || b0.o_first_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_counts c=%0d: got err=%0d txn=%0d vld=%b want 0 0 0",
                         c, b0.o_err_cnt, b0.o_txn_cnt, b0.o_first_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_mismatch();
        test_drop();
        test_mul_trunc();
        test_saturate_clear();
        test_back_to_back_xor();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule

// File: doc/monitor_rr.md
# monitor_rr

Parametrised round-robin scoreboard for an arithmetic DUT. It sits beside the DUT on the testbench clock and accepts one (a, b, DUT result) transaction per valid cycle. Each transaction goes to one of NUM_SUB_MON internal lanes, and each lane computes the reference result over LANE_LAT cycles. The block reports mismatches as pulses, saturating counters and an optional first-failure snapshot. Lanes use clock enables on the single clock; there are no derived clocks.

## Interface
- WIDTH, 32: operand/result width, 1..64.
- NUM_SUB_MON, 4: lane count, >=1.
- LANE_LAT, 4: cycles from accept to compare, >=1.
- OP, 0: reference op. 0 = a+b, 1 = a-b, 2 = a*b, 3 = a^b. Results are truncated to the low WIDTH bits.
- CNT_W, 16: width of the error and transaction counters.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- i_valid  in  1  transaction present this cycle.
- i_dut_ia, i_dut_ib  in  WIDTH  DUT operands.
- i_dut_os  in  WIDTH  DUT result for those operands.
- i_clear  in  1  synchronous clear of counters and snapshot.
- o_ready  out  1  target lane can accept this cycle.
- o_drop  out  1  pulse: valid transaction discarded.
- o_event  out  1  pulse: mismatch detected.
- o_err_cnt  out  CNT_W  mismatches, saturating.
- o_txn_cnt  out  CNT_W  compared transactions, saturating.
- o_first_vld  out  1  snapshot holds a failure.
- o_first_a, o_first_b, o_first_os  out  WIDTH  first failing transaction.

## Operation
- Pointer `ptr` (0..NUM_SUB_MON-1) selects the target lane. It advances by 1 (mod N) only on accept; it does not advance every cycle.
- Lane state: `busy` and a down-counter `cnt`. A lane is done when busy && cnt==0.
- o_ready = !busy[ptr] | done[ptr], combinational.
- Accept = i_valid & o_ready. On accept, the lane captures a, b and os, sets busy, and loads cnt = LANE_LAT-1.
- Discard = i_valid & !o_ready. o_drop pulses in the next cycle, ptr holds and the data is lost.
- Busy lanes decrement cnt each cycle. On the done edge the lane compares expected(OP, a, b) against os and clears busy, unless the same edge re-accepts the lane.
- At most one lane completes per cycle, because accepts are serial and latency is fixed.
- Compare result is registered:
  - o_event high for one cycle on a mismatch.
  - o_txn_cnt increments on every compare.
  - o_err_cnt increments on every mismatch.
  - Both counters stop at 2^CNT_W-1.
- i_clear zeroes both counters and o_first_vld. In-flight lanes are unaffected.
- If a compare lands on the same edge as i_clear, clear is applied first and then that compare is counted, so the counter reads 0 or 1.
- Reset mid-operation aborts all lanes. No event is reported for them.

## Timing
- Reset values: o_drop, o_event, o_first_vld, counters and snapshot all 0. ptr = 0, so o_ready = 1 after reset.
- Latency: accept at edge k gives o_event / count update visible after edge k+LANE_LAT.
- Full rate (i_valid every cycle, no drops) is sustained iff LANE_LAT <= NUM_SUB_MON.
- When LANE_LAT > NUM_SUB_MON, back-to-back valids drop after the first NUM_SUB_MON.

## Configuration
- MONITOR_FIRST_CAPTURE_EN defined:
  - On the first mismatch while o_first_vld==0, o_first_a/b/os latch that lane's captured values and o_first_vld sets.
  - Later mismatches do not overwrite the snapshot.
  - i_clear re-arms the capture.
- Undefined: no snapshot registers; o_first_* tied to 0.

## Test plan
- Defaults (WIDTH=32, N=4, L=4, OP=0), 100 valid cycles with correct sums -> no o_drop, o_event never high, o_txn_cnt=100, o_err_cnt=0.
- Same config, transaction 7 with os = a+b+1 (a=5, b=3, os=9) -> one o_event pulse 4 cycles after its accept, o_err_cnt=1, snapshot = {5, 3, 9}.
- N=2, L=4, continuous valid -> accepts at cycles 0 and 1, o_drop at 2 and 3, accept at 4; ptr does not advance on drops.
- OP=2, WIDTH=8, a=0x10, b=0x10, os=0x00 -> no event (product truncated to 0x00).
- CNT_W=2 with 5 mismatches -> o_err_cnt saturates at 3; i_clear on the 5th compare edge -> o_err_cnt=1.
- Reset asserted with 3 lanes busy, one holding a mismatch -> no o_event after release; o_ready=1 and counters 0.
